sincos_iq_sched: RTL and testbench

Sequencer that shares one sine/cosine core between the sine and cosine halves of an I/Q sample stream. It owns a 32-bit NCO phase accumulator and issues each phase to the core twice: first in sine mode, then in cosine mode. It re-pairs the two in-order core results into one registered I/Q output beat. It sits between the NCO control registers and the `sincos_linear` instance; the core has no stall, so the block issues only against requests and tracks outstanding results.

---
 rtl/sincos_iq_sched.sv | 161 ++++++++++++++++
 tb/tb_sincos_iq_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_iq_sched.sv
// rtl/sincos_iq_sched.sv - NCO sequencer sharing one sin/cos core, re-pairs results into I/Q beats
`timescale 1ns/1ps
module sincos_iq_sched #(
    parameter int OUTPUT_WIDTH = 32,
    parameter int CORE_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             freq_i,
    input  logic                    freq_we,
    input  logic                    phase_clr,
    input  logic                    req_i,
    output logic                    req_ready_o,
    output logic [31:0]             core_phase,
    output logic                    core_mode_cos,
    output logic                    core_valid_o,
    input  logic [OUTPUT_WIDTH-1:0] core_result,
    input  logic                    core_valid_i,
    output logic [OUTPUT_WIDTH-1:0] sin_o,
    output logic [OUTPUT_WIDTH-1:0] cos_o,
    output logic                    iq_valid_o,
    output logic                    err_o
);

    localparam int CW = $clog2(CORE_LATENCY + 3);
    localparam logic [CW-1:0] OUTST_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_SIN, S_COS} state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [31:0]             r_freq;
    logic [31:0]             r_acc;
    logic [31:0]             r_phase_q;
    logic                    r_half;
    logic [OUTPUT_WIDTH-1:0] r_sin_hold;
    logic [CW-1:0]           r_outst;
    logic [OUTPUT_WIDTH-1:0] r_sin;
    logic [OUTPUT_WIDTH-1:0] r_cos;
    logic                    r_iq_valid;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_issue;
    logic                    w_res_ok;
    logic                    w_inc;
    logic [CW-1:0]           w_inc_v;
    logic [CW-1:0]           w_dec_v;

    // A result is only trusted when something is actually in flight.
    assign w_accept = req_i & req_ready_o;
    assign w_issue  = core_valid_o;
    assign w_res_ok = core_valid_i & (r_outst != '0);
    assign w_inc    = w_issue & (r_outst != OUTST_MAX);
    assign w_inc_v  = {{(CW-1){1'b0}}, w_inc};
    assign w_dec_v  = {{(CW-1){1'b0}}, w_res_ok};

    assign sin_o      = r_sin;
    assign cos_o      = r_cos;
    assign iq_valid_o = r_iq_valid;
    assign err_o      = r_err;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    // FSM next state: each accept issues sine then cosine on back-to-back cycles
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = S_SIN;
            S_SIN:   w_state_nx = S_COS;
            S_COS:   w_state_nx = w_accept ? S_SIN : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: core bus is zeroed whenever no issue is in progress
    always_comb begin
        req_ready_o   = 1'b0;
        core_valid_o  = 1'b0;
        core_mode_cos = 1'b0;
        core_phase    = 32'd0;
        case (r_state)
            S_IDLE: req_ready_o = 1'b1;
            S_SIN: begin
                core_valid_o = 1'b1;
                core_phase   = r_phase_q;
            end
            S_COS: begin
                req_ready_o   = 1'b1;
                core_valid_o  = 1'b1;
                core_mode_cos = 1'b1;
                core_phase    = r_phase_q;
            end
            default: req_ready_o = 1'b0;
        endcase
    end

    // Frequency register and phase accumulator; clear wins over accumulate,
    // and an accept always steps by the frequency held before this cycle's write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_freq    <= 32'd0;
            r_acc     <= 32'd0;
            r_phase_q <= 32'd0;
        end else begin
            if (freq_we) r_freq <= freq_i;
            if (w_accept) begin
                if (phase_clr) begin
                    r_phase_q <= 32'd0;
                    r_acc     <= r_freq;
                end else begin
                    r_phase_q <= r_acc;
                    r_acc     <= r_acc + r_freq;
                end
            end else if (phase_clr) begin
                r_acc <= 32'd0;
            end
        end
    end

    // Outstanding-result tracking and sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_outst <= r_outst + w_inc_v - w_dec_v;
            if ((core_valid_i && r_outst == '0) || (w_issue && r_outst == OUTST_MAX))
                r_err <= 1'b1;
        end
    end

    // Re-pair in-order sine/cosine results into one registered I/Q beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_half     <= 1'b0;
            r_sin_hold <= '0;
            r_sin      <= '0;
            r_cos      <= '0;
            r_iq_valid <= 1'b0;
        end else begin
            r_iq_valid <= 1'b0;
            if (w_res_ok) begin
                if (!r_half) begin
                    r_sin_hold <= core_result;
                    r_half     <= 1'b1;
                end else begin
                    r_sin      <= r_sin_hold;
                    r_cos      <= core_result;
                    r_iq_valid <= 1'b1;
                    r_half     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sincos_iq_sched.sv
// tb/tb_sincos_iq_sched.sv - directed self-checking bench for sincos_iq_sched
`timescale 1ns/1ps
module tb_sincos_iq_sched;

    localparam int OW = 32;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   freq_i = '0;
    logic          freq_we = 1'b0;
    logic          phase_clr = 1'b0;
    logic          req_i = 1'b0;
    logic          req_ready_o;
    logic [31:0]   core_phase;
    logic          core_mode_cos;
    logic          core_valid_o;
    logic [OW-1:0] core_result;
    logic          core_valid_i;
    logic [OW-1:0] sin_o;
    logic [OW-1:0] cos_o;
    logic          iq_valid_o;
    logic          err_o;

    logic          inj_v = 1'b0;
    logic [OW-1:0] inj_d = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [32:0] issue_q[$];
    logic [63:0] iq_q[$];
    int          iq_cyc[$];

    sincos_iq_sched #(.OUTPUT_WIDTH(OW), .CORE_LATENCY(L)) dut (
        .clk(clk), .reset(rst), .freq_i(freq_i), .freq_we(freq_we),
        .phase_clr(phase_clr), .req_i(req_i), .req_ready_o(req_ready_o),
        .core_phase(core_phase), .core_mode_cos(core_mode_cos),
        .core_valid_o(core_valid_o), .core_result(core_result),
        .core_valid_i(core_valid_i), .sin_o(sin_o), .cos_o(cos_o),
        .iq_valid_o(iq_valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Toy core: fixed latency L, sine mode returns the phase, cosine mode its complement
    logic [L-1:0] pv;
    logic         pm [L];
    logic [31:0]  pp [L];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            for (int k = 0; k < L; k++) begin
                pm[k] <= 1'b0;
                pp[k] <= '0;
            end
        end else begin
            pv[0] <= core_valid_o;
            pm[0] <= core_mode_cos;
            pp[0] <= core_phase;
            for (int k = 1; k < L; k++) begin
                pv[k] <= pv[k-1];
                pm[k] <= pm[k-1];
                pp[k] <= pp[k-1];
            end
        end
    end
    assign core_valid_i = pv[L-1] | inj_v;
    assign core_result  = inj_v ? inj_d : (pm[L-1] ? ~pp[L-1] : pp[L-1]);

    always @(negedge clk) begin
        if (!rst) begin
            if (core_valid_o) issue_q.push_back({core_mode_cos, core_phase});
            if (iq_valid_o) begin
                iq_q.push_back({sin_o, cos_o});
                iq_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        freq_we = 1'b0;
        phase_clr = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_iq(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            if (iq_valid_o) begin
                c = cyc;
                break;
            end
            tick();
        end
        if (c < 0) chk("iq_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        repeat (16) tick();
        issue_q.delete();
        iq_q.delete();
        iq_cyc.delete();
    endtask

    initial begin
        int t0;
        int c;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_cvalid", core_valid_o, 0);
        chk("rst_phase", core_phase, 0);
        chk("rst_iq", iq_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sincos", {sin_o, cos_o}, 0);
        rst = 1'b0;
        tick();

        // Single request, freq = quarter turn
        freq_i = 32'h4000_0000;
        freq_we = 1'b1;
        tick();
        freq_we = 1'b0;
        req_i = 1'b1;
        t0 = cyc;
        tick();
        req_i = 1'b0;
        chk("t1_sin_ready", req_ready_o, 0);
        chk("t1_sin_issue", {core_valid_o, core_mode_cos, core_phase}, {1'b1, 1'b0, 32'h0});
        tick();
        chk("t1_cos_ready", req_ready_o, 1);
        chk("t1_cos_issue", {core_valid_o, core_mode_cos, core_phase}, {1'b1, 1'b1, 32'h0});
        tick();
        chk("t1_idle_bus", {core_valid_o, core_mode_cos, core_phase}, 0);
        wait_iq(c);
        chk("t1_iq_latency", c - t0, 3 + L);
        chk("t1_iq_data", {sin_o, cos_o}, 64'h0000_0000_FFFF_FFFF);
        tick();
        chk("t1_iq_pulse", iq_valid_o, 0);
        drain();

        // Back-to-back: four accepts from a cleared accumulator
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        req_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("t2_ready_%0d", k), req_ready_o, (k % 2 == 0) ? 1 : 0);
            tick();
        end
        req_i = 1'b0;
        repeat (16) tick();
        chk("t2_issue_cnt", issue_q.size(), 8);
        for (int k = 0; k < 8 && k < issue_q.size(); k++)
            chk($sformatf("t2_issue_%0d", k), issue_q[k],
                {(k % 2 == 1) ? 1'b1 : 1'b0, 32'(k / 2) << 30});
        chk("t2_iq_cnt", iq_q.size(), 4);
        for (int k = 0; k < 4 && k < iq_q.size(); k++)
            chk($sformatf("t2_iq_%0d", k), iq_q[k], {32'(k) << 30, ~(32'(k) << 30)});
        for (int k = 1; k < 4 && k < iq_cyc.size(); k++)
            chk($sformatf("t2_iq_gap_%0d", k), iq_cyc[k] - iq_cyc[k-1], 2);
        drain();

        // Wrap and same-cycle frequency write
        phase_clr = 1'b1;
        freq_i = 32'hC000_0000;
        freq_we = 1'b1;
        tick();
        phase_clr = 1'b0;
        freq_we = 1'b0;
        do_req();
        freq_i = 32'h1000_0000;
        freq_we = 1'b1;
        do_req();
        do_req();
        do_req();
        repeat (12) tick();
        chk("t3_issue_cnt", issue_q.size(), 8);
        if (issue_q.size() == 8) begin
            chk("t3_ph0", issue_q[0], {1'b0, 32'h0000_0000});
            chk("t3_ph1", issue_q[2], {1'b0, 32'hC000_0000});
            chk("t3_wrap", issue_q[4], {1'b0, 32'h8000_0000});
            chk("t3_newfreq", issue_q[6], {1'b0, 32'h9000_0000});
        end
        chk("t3_err", err_o, 0);
        drain();

        // Clear and accept in the same cycle
        phase_clr = 1'b1;
        freq_i = 32'h1234_5678;
        freq_we = 1'b1;
        tick();
        phase_clr = 1'b0;
        freq_we = 1'b0;
        do_req();
        freq_i = 32'h10;
        freq_we = 1'b1;
        tick();
        freq_we = 1'b0;
        phase_clr = 1'b1;
        do_req();
        do_req();
        repeat (12) tick();
        chk("t4_issue_cnt", issue_q.size(), 6);
        if (issue_q.size() == 6) begin
            chk("t4_setup", issue_q[0], {1'b0, 32'h0});
            chk("t4_clr_sin", issue_q[2], {1'b0, 32'h0});
            chk("t4_clr_cos", issue_q[3], {1'b1, 32'h0});
            chk("t4_after", issue_q[4], {1'b0, 32'h10});
        end
        drain();

        // Spurious core result with nothing outstanding
        chk("t5_err_pre", err_o, 0);
        inj_d = 32'hDEAD_BEEF;
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        chk("t5_err_set", err_o, 1);
        repeat (5) tick();
        chk("t5_err_hold", err_o, 1);
        chk("t5_no_iq", iq_q.size(), 0);
        do_req();
        wait_iq(c);
        chk("t5_pair", {sin_o, cos_o}, {32'h20, 32'hFFFF_FFDF});
        chk("t5_err_sticky", err_o, 1);
        drain();

        // Reset between sine and cosine issue
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        chk("t6_in_sin", core_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_bus", {core_valid_o, core_mode_cos, core_phase}, 0);
        chk("t6_rst_ready", req_ready_o, 1);
        chk("t6_rst_out", {iq_valid_o, err_o, sin_o, cos_o}, 0);
        tick();
        rst = 1'b0;
        tick();
        issue_q.delete();
        iq_q.delete();
        iq_cyc.delete();
        freq_i = 32'h100;
        freq_we = 1'b1;
        tick();
        freq_we = 1'b0;
        do_req();
        do_req();
        repeat (12) tick();
        chk("t6_iq_cnt", iq_q.size(), 2);
        if (iq_q.size() == 2) begin
            chk("t6_iq0", iq_q[0], {32'h0, 32'hFFFF_FFFF});
            chk("t6_iq1", iq_q[1], {32'h100, 32'hFFFF_FEFF});
        end
        chk("t6_err", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
